// File: rtl/exe_muldiv_unit.sv
// Iterative 32-bit multiply/divide unit: one shift-add or restoring divide step per cycle.
// Define MULDIV_DIV_EN to include DIV/DIVU; the default build is multiply-only.
module exe_muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] Val1,
   input  logic [31:0] Val2,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic        div0,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic [31:0] acc_hi, acc_lo, opd;
   logic [31:0] hi_q, lo_q;
   logic        neg_q;
   logic        op_ok, sel_div, accept, last;
   logic        s1, s2;
   logic [31:0] abs1, abs2;
   logic [32:0] sum;
   logic [31:0] st_hi, st_lo;
   logic [63:0] prod;
   logic [31:0] res_hi, res_lo;
   logic        is_div;

`ifdef MULDIV_DIV_EN
   logic        dz_r, neg_r;
   logic [32:0] sh, diff;

   assign op_ok   = 1'b1;
   assign sel_div = op[1];
`else
   assign op_ok   = ~op[1];
   assign sel_div = 1'b0;
   assign is_div  = 1'b0;
`endif

   assign accept = start & ~flush & (state != RUN) & op_ok;
   assign last   = (state == RUN) & (cnt == 5'd0) & ~flush;

   // op[0]=0 selects the signed variants
   assign s1   = ~op[0] & Val1[31];
   assign s2   = ~op[0] & Val2[31];
   assign abs1 = s1 ? 32'd0 - Val1 : Val1;
   assign abs2 = s2 ? 32'd0 - Val2 : Val2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (flush) state_nxt = IDLE;
                  else if (cnt == 5'd0) state_nxt = DONE;
         DONE:    state_nxt = accept ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : 33'd0);
      st_hi = sum[32:1];
      st_lo = {sum[0], acc_lo[31:1]};
`ifdef MULDIV_DIV_EN
      // remainder stays below the divisor, so bit 32 of diff is the borrow
      sh   = {acc_hi, acc_lo[31]};
      diff = sh - {1'b0, opd};
      if (is_div) begin
         st_hi = diff[32] ? sh[31:0] : diff[31:0];
         st_lo = {acc_lo[30:0], ~diff[32]};
      end
`endif
   end

   always_comb begin
      prod   = neg_q ? 64'd0 - {st_hi, st_lo} : {st_hi, st_lo};
      res_hi = prod[63:32];
      res_lo = prod[31:0];
`ifdef MULDIV_DIV_EN
      if (is_div) begin
         res_hi = neg_r ? 32'd0 - st_hi : st_hi;
         res_lo = dz_r ? 32'hFFFF_FFFF
                : (neg_q ? 32'd0 - st_lo : st_lo);
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= 5'd0;
         acc_hi <= 32'd0;
         acc_lo <= 32'd0;
         opd    <= 32'd0;
         neg_q  <= 1'b0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
      end else begin
         if (accept) begin
            cnt    <= 5'd31;
            acc_hi <= 32'd0;
            acc_lo <= sel_div ? abs1 : abs2;
            opd    <= sel_div ? abs2 : abs1;
            neg_q  <= s1 ^ s2;
         end else if (state == RUN) begin
            acc_hi <= st_hi;
            acc_lo <= st_lo;
            if (cnt != 5'd0) cnt <= cnt - 5'd1;
         end
         if (last) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end
      end
   end

`ifdef MULDIV_DIV_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         is_div <= 1'b0;
         dz_r   <= 1'b0;
         neg_r  <= 1'b0;
      end else if (accept) begin
         is_div <= op[1];
         dz_r   <= op[1] & (Val2 == 32'd0);
         neg_r  <= s1;
      end
   end

   assign div0 = done & dz_r;
`else
   assign div0 = 1'b0;
`endif

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed bench for exe_muldiv_unit; divide vectors run only when MULDIV_DIV_EN is defined.
module tb_exe_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] Val1, Val2;
   logic        flush;
   logic        busy, done, div0;
   logic [31:0] HI, LO;

   int n_chk = 0;
   int n_bad = 0;

   localparam logic [1:0] MULT  = 2'b00;
   localparam logic [1:0] MULTU = 2'b01;
   localparam logic [1:0] DIV   = 2'b10;
   localparam logic [1:0] DIVU  = 2'b11;

   exe_muldiv_unit dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .Val1  (Val1),
      .Val2  (Val2),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .div0  (div0),
      .HI    (HI),
      .LO    (LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // issue at a negedge; returns at the negedge after the accepting edge
   task automatic go(input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic hold);
      @(negedge clk);
      op = o; Val1 = a; Val2 = b; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   // e counts edges with the accepting edge as edge 1
   task automatic wait_done(input int e0, output int e, output int nb);
      e  = e0;
      nb = 0;
      while (!done && e < 80) begin
         if (busy) nb++;
         @(posedge clk);
         e++;
         @(negedge clk);
      end
   endtask

   task automatic run(input string tag, input logic [1:0] o,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el,
                      input logic ez);
      int e, nb;
      go(o, a, b, 1'b0);
      wait_done(1, e, nb);
      chk({tag, " edges"}, 64'(e), 64'd33);
      chk({tag, " busy"}, 64'(nb), 64'd32);
      chk({tag, " HI"}, 64'(HI), 64'(eh));
      chk({tag, " LO"}, 64'(LO), 64'(el));
      chk({tag, " div0"}, 64'(div0), 64'(ez));
      @(negedge clk);
      chk({tag, " done1"}, 64'(done), 64'd0);
      chk({tag, " div0off"}, 64'(div0), 64'd0);
   endtask

   initial begin
      int e, nb, nd, nbz;
      rst = 1'b0; start = 1'b0; flush = 1'b0;
      op = 2'b00; Val1 = '0; Val2 = '0;
      repeat (2) @(negedge clk);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst div0", 64'(div0), 64'd0);
      chk("rst HILO", {HI, LO}, 64'd0);
      rst = 1'b1;

      run("mulu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run("mul_n3x7", MULT, 32'hFFFF_FFFD, 32'd7,
          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run("mul_n5n6", MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA,
          32'd0, 32'd30, 1'b0);
      run("mul_minsq", MULT, 32'h8000_0000, 32'h8000_0000,
          32'h4000_0000, 32'd0, 1'b0);
      run("mul_minx1", MULT, 32'h8000_0000, 32'd1,
          32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
      run("mulu_sh4", MULTU, 32'h1234_5678, 32'h10,
          32'd1, 32'h2345_6780, 1'b0);

      // start pulse in RUN cycle 5 must not restart or change operands
      go(MULTU, 32'd3, 32'd4, 1'b0);
      repeat (4) @(negedge clk);
      start = 1'b1; Val1 = 32'd100; Val2 = 32'd100;
      @(negedge clk);
      start = 1'b0;
      wait_done(6, e, nb);
      chk("ign edges", 64'(e), 64'd33);
      chk("ign LO", {HI, LO}, 64'd12);

      // back-to-back: start held through DONE
      go(MULTU, 32'd2, 32'd3, 1'b1);
      Val1 = 32'd5; Val2 = 32'd5;
      wait_done(1, e, nb);
      chk("b2b1 edges", 64'(e), 64'd33);
      chk("b2b1 res", {HI, LO}, 64'd6);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("b2b busy", 64'(busy), 64'd1);
      chk("b2b done", 64'(done), 64'd0);
      wait_done(1, e, nb);
      chk("b2b2 edges", 64'(e), 64'd33);
      chk("b2b2 res", {HI, LO}, 64'd25);

      // flush at RUN cycle 10
      go(MULTU, 32'd7, 32'd7, 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush busy", 64'(busy), 64'd0);
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      chk("flush quiet", 64'(nd), 64'd0);
      chk("flush HILO", {HI, LO}, 64'd25);

      // flush with start wins
      @(negedge clk);
      op = MULTU; Val1 = 32'd9; Val2 = 32'd9;
      start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("fl_st busy", 64'(busy), 64'd0);

`ifdef MULDIV_DIV_EN
      run("div_n7_2", DIV, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run("divu_z", DIVU, 32'd100, 32'd0,
          32'd100, 32'hFFFF_FFFF, 1'b1);
      run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
          32'd0, 32'h8000_0000, 1'b0);
      run("divu_100_7", DIVU, 32'd100, 32'd7,
          32'd2, 32'd14, 1'b0);
      run("div_7_n2", DIV, 32'd7, 32'hFFFF_FFFE,
          32'd1, 32'hFFFF_FFFD, 1'b0);
      run("div_nz", DIV, 32'hFFFF_FFF6, 32'd0,
          32'hFFFF_FFF6, 32'hFFFF_FFFF, 1'b1);
`else
      // divide disabled: request is ignored entirely
      go(DIV, 32'd10, 32'd2, 1'b0);
      chk("nodiv busy", 64'(busy), 64'd0);
      nd = 0; nbz = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) nd++;
         if (busy) nbz++;
      end
      chk("nodiv done", 64'(nd), 64'd0);
      chk("nodiv busy2", 64'(nbz), 64'd0);
      chk("nodiv HILO", {HI, LO}, 64'd25);
`endif

      // reset at RUN cycle 20 clears outputs at once
      go(MULTU, 32'd11, 32'd13, 1'b0);
      repeat (19) @(negedge clk);
      chk("pre rst busy", 64'(busy), 64'd1);
      rst = 1'b0;
      #1;
      chk("mid rst busy", 64'(busy), 64'd0);
      chk("mid rst done", 64'(done), 64'd0);
      chk("mid rst HILO", {HI, LO}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      op = MULTU; Val1 = 32'd6; Val2 = 32'd7; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("post rst busy", 64'(busy), 64'd1);
      wait_done(1, e, nb);
      chk("post rst edges", 64'(e), 64'd33);
      chk("post rst res", {HI, LO}, 64'd42);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/exe_muldiv_unit.md
EXE_MULDIV_UNIT -- requirements
Module: exe_muldiv_unit

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32.
REQ-002 clk  in  1  Single clock; all state updates on its rising edge.
REQ-003 rst  in  1  Reset, asynchronous, active-low.
REQ-004 start  in  1  Operation request from the ID/EXE pipeline register outputs.
REQ-005 op  in  2  Operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Val1  in  32  Multiplicand or dividend.
REQ-007 Val2  in  32  Multiplier or divisor.
REQ-008 flush  in  1  Abort request from the branch/hazard logic.
REQ-009 busy  out  1  High while an operation is in progress; drives the pipeline stall.
REQ-010 done  out  1  One-cycle pulse marking the cycle in which HI/LO first hold the new result.
REQ-011 div0  out  1  One-cycle pulse, coincident with done, for a divide with Val2 == 0.
REQ-012 HI  out  32  Upper product word, or remainder.
REQ-013 LO  out  32  Lower product word, or quotient.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE; busy = (state == RUN).
REQ-015 In IDLE or DONE, start=1 with flush=0 SHALL latch op, Val1 and Val2 and go to RUN with the iteration counter set to 31.
- The latch SHALL take absolute values for signed ops.
- The latch SHALL record the result signs.
REQ-016 RUN SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle, decrementing the counter.
REQ-017 When the counter is 0, RUN SHALL go to DONE and write HI/LO on the same edge, applying the sign fixup on that edge.
- Result is valid 33 edges after the start edge.
- done SHALL be high for exactly the one DONE cycle.
REQ-018 DONE SHALL go to IDLE on the next edge unless a new start is accepted (back-to-back, REQ-015).
REQ-019 start asserted in RUN SHALL be ignored.
REQ-020 Signed multiply SHALL give the exact 64-bit two's-complement product.
REQ-021 Unsigned multiply SHALL give the exact 64-bit unsigned product.
REQ-022 Signed divide SHALL truncate toward zero; the remainder takes the sign of the dividend.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0 (wrap, no flag).
REQ-024 Divide with Val2 == 0 SHALL still take the full latency and give LO=0xFFFFFFFF, HI=Val1, with div0=1 in the DONE cycle.
REQ-025 flush=1 in RUN SHALL return the FSM to IDLE on the next edge, leave HI/LO unchanged and produce no done pulse.
REQ-026 flush=1 coincident with start SHALL win: start is ignored.
REQ-027 HI/LO SHALL change only on the RUN->DONE edge and SHALL hold otherwise.

Reset
REQ-028 While rst=0, the block SHALL asynchronously force the following:
- state=IDLE, counter=0
- busy=0, done=0, div0=0
- HI=0, LO=0
- all internal operand registers to 0
REQ-029 rst asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-030 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-031 With macro MULDIV_DIV_EN defined, all four ops SHALL be supported as specified.
REQ-032 Without MULDIV_DIV_EN:
- the divide datapath SHALL be omitted;
- start with op[1]=1 SHALL be ignored (FSM stays IDLE/DONE->IDLE, busy=0, no done, HI/LO unchanged);
- div0 SHALL be tied 0.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 33 edges after start; HI=0xFFFFFFFE, LO=0x00000001; busy high for 32 cycles.
REQ-034 MULT 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-035 DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100, div0 pulse.
REQ-036 Back-to-back start held high through DONE -> second op enters RUN with no IDLE cycle.
- start pulsed during RUN -> ignored.
REQ-037 flush at RUN cycle 10 -> IDLE next edge, no done, HI/LO keep prior values.
- rst=0 at RUN cycle 20 -> all outputs 0 immediately.
REQ-038 Build without MULDIV_DIV_EN, DIV 10 / 2 -> busy stays 0, no done, HI/LO unchanged.
